// File: rtl/pwm_generator_if.sv
// PWM generator control/status bundle.
//   master : drives tick, enable, duty/period and the load strobe; observes status.
//   slave  : the PWM generator itself.
//   Signals: tick_i, enable_i, duty_i, period_i, load_i (to generator)
//            load_pending_o, load_ack_o, cycle_o, count_o, pwm_o (from generator)
interface pwm_generator_if #(
  parameter int unsigned WIDTH = 16
);
  logic             tick_i;
  logic             enable_i;
  logic [WIDTH-1:0] duty_i;
  logic [WIDTH-1:0] period_i;
  logic             load_i;
  logic             load_pending_o;
  logic             load_ack_o;
  logic             cycle_o;
  logic [WIDTH-1:0] count_o;
  logic             pwm_o;

  modport master (
    output tick_i, enable_i, duty_i, period_i, load_i,
    input  load_pending_o, load_ack_o, cycle_o, count_o, pwm_o
  );

  modport slave (
    input  tick_i, enable_i, duty_i, period_i, load_i,
    output load_pending_o, load_ack_o, cycle_o, count_o, pwm_o
  );
endinterface

// File: rtl/pwm_generator.sv
// Tick-driven single-channel PWM generator with double-buffered duty/period.
//   clk_i  : system clock, all logic on rising edge
//   reset  : asynchronous active-low reset
//   bus    : pwm_generator_if slave modport (tick/enable/load inputs, status and pwm outputs)
// New duty/period values wait in a shadow register and only become active on a
// period boundary, so a running pulse is never cut short or stretched.
module pwm_generator #(
  parameter int unsigned WIDTH = 16
) (
  input  logic           clk_i,
  input  logic           reset,
  pwm_generator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } state_e;

  typedef struct packed {
    logic [WIDTH-1:0] duty;
    logic [WIDTH-1:0] period;
  } cfg_t;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  cfg_t             active_q, active_d;
  cfg_t             shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             ack_q, ack_d;
  logic             cycle_q, cycle_d;
  logic             pwm_q, pwm_d;
  logic             tick_q;

  logic             tick_rise;
  logic             at_end;
  logic             boundary;
  cfg_t             load_cfg;

  assign tick_rise = bus.tick_i & ~tick_q;
  assign load_cfg  = '{duty: bus.duty_i, period: bus.period_i};

  // Last count of the period; period 0 wraps on every tick (no subtract underflow).
  always_comb begin
    at_end = 1'b1;
    if (active_q.period != '0) begin
      at_end = (count_q >= (active_q.period - WIDTH'(1)));
    end
  end

  // Next-state, counter, handshake and output decode.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    ack_d     = 1'b0;
    cycle_d   = 1'b0;
    boundary  = 1'b0;

    if (bus.load_i) begin
      shadow_d  = load_cfg;
      pending_d = 1'b1;
    end

    // Disable wins over any tick in the same cycle.
    if (!bus.enable_i) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          count_d = '0;
          state_d = START;
        end
        START: begin
          if (tick_rise) begin
            count_d  = '0;
            boundary = 1'b1;
            state_d  = RUN;
          end
        end
        RUN: begin
          if (tick_rise) begin
            if (at_end) begin
              count_d  = '0;
              boundary = 1'b1;
            end else begin
              count_d = count_q + WIDTH'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end

    // Apply event: a load in this very cycle beats the older shadow contents.
    if (boundary) begin
      cycle_d = 1'b1;
      if (bus.load_i || pending_q) begin
        active_d  = bus.load_i ? load_cfg : shadow_q;
        pending_d = 1'b0;
        ack_d     = 1'b1;
      end
    end

    pwm_d = bus.enable_i && (state_q == RUN) && (active_q.period != '0) &&
            (count_q < active_q.duty);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
      cycle_q   <= 1'b0;
      pwm_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
      cycle_q   <= cycle_d;
      pwm_q     <= pwm_d;
      tick_q    <= bus.tick_i;
    end
  end

  assign bus.load_pending_o = pending_q;
  assign bus.load_ack_o     = ack_q;
  assign bus.cycle_o        = cycle_q;
  assign bus.count_o        = count_q;
  assign bus.pwm_o          = pwm_q;

endmodule

// File: tb/tb_pwm_generator.sv
// Testbench for pwm_generator: directed scenarios followed by random traffic,
// checked against a tick-level model (phase within period, active/shadow settings).
module tb_pwm_generator;
  localparam int unsigned WIDTH = 16;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pwm_generator_if #(.WIDTH(WIDTH)) bus ();

  pwm_generator #(.WIDTH(WIDTH)) dut (
    .clk_i (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state, advanced once per tick.
  int m_duty, m_period, m_sh_duty, m_sh_period, m_pos;
  bit m_pending, m_en, m_run;

  int obs_pwm, obs_cyc, sum_pwm, sum_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_duty = 0; m_period = 0; m_sh_duty = 0; m_sh_period = 0;
    m_pos = 0; m_pending = 0; m_en = 0; m_run = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_count"},   bus.count_o, 0);
    chk({tag, "_pwm"},     bus.pwm_o, 0);
    chk({tag, "_cycle"},   bus.cycle_o, 0);
    chk({tag, "_ack"},     bus.load_ack_o, 0);
    chk({tag, "_pending"}, bus.load_pending_o, 0);
  endtask

  task automatic do_load(input int d, input int p);
    bus.duty_i   = WIDTH'(d);
    bus.period_i = WIDTH'(p);
    bus.load_i   = 1'b1;
    @(negedge clk);
    bus.load_i   = 1'b0;
    m_sh_duty = d; m_sh_period = p; m_pending = 1;
    chk("load_pending", bus.load_pending_o, 1);
    chk("load_noack", bus.load_ack_o, 0);
  endtask

  task automatic set_enable(input bit en);
    if (en) begin
      bus.enable_i = 1'b1;
      wait_clk(2);
      m_en = 1;
    end else begin
      bus.enable_i = 1'b0;
      @(negedge clk);
      m_en = 0; m_run = 0; m_pos = 0;
      chk("dis_count", bus.count_o, 0);
      chk("dis_pwm", bus.pwm_o, 0);
      chk("dis_cycle", bus.cycle_o, 0);
    end
  endtask

  // One tick: high for hi clocks (>=2), then low for lo clocks; optional load on the rising edge.
  task automatic tick(input int hi, input int lo, input bit ld, input int d, input int p);
    bit e_cyc, e_ack, e_pwm, bnd;
    int e_cnt;
    bus.tick_i = 1'b1;
    if (ld) begin
      bus.duty_i = WIDTH'(d); bus.period_i = WIDTH'(p); bus.load_i = 1'b1;
    end
    e_cyc = 0; e_ack = 0; bnd = 0;
    if (m_en) begin
      if (!m_run) begin
        m_run = 1; bnd = 1;
      end else if (m_period == 0 || m_pos + 1 >= m_period) begin
        bnd = 1;
      end else begin
        m_pos++;
      end
    end
    if (ld) begin
      m_sh_duty = d; m_sh_period = p; m_pending = 1;
    end
    if (bnd) begin
      m_pos = 0; e_cyc = 1;
      if (m_pending) begin
        m_duty = m_sh_duty; m_period = m_sh_period; m_pending = 0; e_ack = 1;
      end
    end
    e_cnt = m_pos;
    e_pwm = m_run && (m_period != 0) && (m_pos < m_duty);

    @(negedge clk);
    bus.load_i = 1'b0;
    chk("tick_cycle", bus.cycle_o, e_cyc);
    chk("tick_ack", bus.load_ack_o, e_ack);
    chk("tick_count", bus.count_o, e_cnt);
    chk("tick_pending", bus.load_pending_o, m_pending);
    obs_cyc = int'(bus.cycle_o);
    @(negedge clk);
    chk("tick_pwm", bus.pwm_o, e_pwm);
    chk("tick_cycle_pulse", bus.cycle_o, 0);
    chk("tick_ack_pulse", bus.load_ack_o, 0);
    obs_pwm = int'(bus.pwm_o);
    wait_clk(hi - 2);
    bus.tick_i = 1'b0;
    wait_clk(lo);
    chk("hold_count", bus.count_o, e_cnt);
    chk("hold_pwm", bus.pwm_o, e_pwm);
  endtask

  task automatic run_ticks(input int n);
    sum_pwm = 0; sum_cyc = 0;
    repeat (n) begin
      tick(2, 2, 0, 0, 0);
      sum_pwm += obs_pwm;
      sum_cyc += obs_cyc;
    end
  endtask

  // Tick until the pending shadow has been applied (bounded).
  task automatic sync_apply();
    for (int i = 0; i < 40; i++) begin
      if (!bus.load_pending_o) break;
      tick(2, 2, 0, 0, 0);
    end
    chk("apply_reached", bus.load_pending_o, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.tick_i = 1'b0; bus.enable_i = 1'b0; bus.load_i = 1'b0;
    bus.duty_i = '0; bus.period_i = '0;
    model_reset();
    wait_clk(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    wait_clk(1);

    // 3/8 pattern: ack on first tick, 3 high of 8, one cycle pulse per period.
    do_load(3, 8);
    set_enable(1);
    run_ticks(8);
    chk("p38_high_a", sum_pwm, 3);
    chk("p38_cycles_a", sum_cyc, 1);
    run_ticks(8);
    chk("p38_high_b", sum_pwm, 3);
    chk("p38_cycles_b", sum_cyc, 1);

    // Reload 6/10 mid-period at count 2: old period finishes untouched.
    run_ticks(3);
    do_load(6, 10);
    run_ticks(5);
    chk("reload_old_high", sum_pwm, 0);
    chk("reload_old_cycles", sum_cyc, 0);
    run_ticks(10);
    chk("reload_new_high", sum_pwm, 6);
    chk("reload_new_cycles", sum_cyc, 1);

    // Asynchronous reset while pwm is high.
    tick(2, 2, 0, 0, 0);
    chk("pre_reset_pwm", bus.pwm_o, 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    bus.enable_i = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick(2, 2, 0, 0, 0);

    // tick_i high across reset release is not an edge.
    rst_n = 1'b0;
    bus.tick_i = 1'b1;
    bus.enable_i = 1'b1;
    wait_clk(2);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rel_hi_cycle", bus.cycle_o, 0);
      chk("rel_hi_count", bus.count_o, 0);
    end
    bus.tick_i = 1'b0;
    wait_clk(1);
    m_en = 1;
    do_load(2, 4);
    tick(2, 2, 0, 0, 0);
    tick(2, 2, 0, 0, 0);

    // Long tick: one increment only.
    tick(20, 2, 0, 0, 0);
    chk("long_tick_count", bus.count_o, 2);

    // Edge cases on duty/period.
    do_load(0, 5);
    sync_apply();
    run_ticks(10);
    chk("duty0_high", sum_pwm, 0);
    chk("duty0_cycles", sum_cyc, 2);
    do_load(9, 5);
    sync_apply();
    run_ticks(10);
    chk("duty9_high", sum_pwm, 10);
    chk("duty9_cycles", sum_cyc, 2);
    do_load(3, 0);
    sync_apply();
    run_ticks(6);
    chk("per0_high", sum_pwm, 0);
    chk("per0_cycles", sum_cyc, 6);
    tick(2, 2, 1, 2, 6);

    // Disable at count 4, then restart through START.
    for (int i = 0; i < 12; i++) begin
      if (bus.count_o == WIDTH'(4)) break;
      tick(2, 2, 0, 0, 0);
    end
    chk("reach_count4", bus.count_o, 4);
    set_enable(0);
    set_enable(1);
    tick(2, 2, 0, 0, 0);
    tick(2, 2, 0, 0, 0);

    // Disable coincident with a tick rise: no cycle pulse.
    bus.enable_i = 1'b0;
    bus.tick_i = 1'b1;
    @(negedge clk);
    chk("dis_tick_cycle", bus.cycle_o, 0);
    chk("dis_tick_count", bus.count_o, 0);
    chk("dis_tick_pwm", bus.pwm_o, 0);
    bus.tick_i = 1'b0;
    m_en = 0; m_run = 0; m_pos = 0;
    wait_clk(1);
    set_enable(1);

    // Random traffic.
    for (int it = 0; it < 250; it++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r < 3) begin
        do_load(int'($urandom_range(0, 12)), int'($urandom_range(0, 12)));
      end else if (r < 5) begin
        tick(2, 1, 1, int'($urandom_range(0, 12)), int'($urandom_range(0, 12)));
      end else if (r == 5) begin
        set_enable(0);
        if ($urandom_range(0, 1) == 1) tick(2, 1, 0, 0, 0);
        set_enable(1);
      end else begin
        tick(int'($urandom_range(2, 4)), int'($urandom_range(1, 3)), 0, 0, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_generator.md
Name: pwm_generator

Overview:
Tick-driven PWM generator that consumes the divided-clock output of the clock divider on tick_i and produces one PWM channel, e.g. for a motor or servo drive.
- tick_i is used only as an edge-detected count enable; the block itself runs entirely on clk_i.
- Duty and period are double-buffered through a shadow register with a load/ack handshake, so updates take effect only on period boundaries and never produce glitched pulses.

Parameters:
WIDTH, 16, width of counter, duty and period values.

Ports:
clk_i  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset.
tick_i  input  1  divided clock from the clock divider, synchronous to clk_i; each rising edge advances the PWM counter by one.
enable_i  input  1  run request; low forces output idle.
duty_i  input  WIDTH  requested high time, in ticks.
period_i  input  WIDTH  requested period, in ticks.
load_i  input  1  one-cycle strobe; captures duty_i/period_i into the shadow registers.
load_pending_o  output  1  shadow holds values not yet applied.
load_ack_o  output  1  one-cycle pulse when shadow values become active.
cycle_o  output  1  one-cycle pulse at the start of every PWM period.
count_o  output  WIDTH  current counter value (debug/verification).
pwm_o  output  1  PWM output.

Behaviour:
Reset (reset low, asynchronous):
- State IDLE; count, duty_a, period_a, shadow registers and tick_q all 0.
- All outputs 0.

Edge detect:
- tick_q <= tick_i every clk.
- tick_rise = tick_i & ~tick_q.
- tick_i high coming out of reset does not count as an edge.

Load handshake:
- load_i in any state: shadow <= {duty_i, period_i}; load_pending_o <= 1.
- A second load before apply overwrites the shadow; no ack is issued for the overwritten values.

Apply event:
- At each period boundary, if load_pending_o = 1 or load_i = 1 in that cycle: active <= shadow, with load_i inputs taking precedence when both are present.
- On apply: load_pending_o <= 0; load_ack_o = 1 for exactly one clk.

State machine:
- IDLE: count held 0; pwm_o 0. enable_i = 1 -> START.
- START: waits for tick_rise. On tick_rise: count <= 0, apply event, cycle_o pulse, -> RUN.
- RUN, on tick_rise:
  - If count >= period_a - 1 or period_a == 0: boundary. count <= 0, apply event, cycle_o pulse.
  - Otherwise: count <= count + 1.
  - No tick_rise: count holds.
- Any state, enable_i = 0 -> IDLE next clk: count <= 0, pwm_o <= 0. Shadow and load_pending_o are preserved. Active values are preserved but are re-applied only if pending.

Output:
- pwm_o registered: pwm_o <= (state == RUN) && (period_a != 0) && (count < duty_a).
- pwm_o therefore lags count by one clk.
- duty_a = 0 gives constant low; duty_a >= period_a gives constant high in RUN.

Arithmetic:
- Unsigned WIDTH-bit compares; period_a - 1 is evaluated only when period_a != 0. No overflow possible because count <= period_a - 1.
- cycle_o and load_ack_o are registered, asserted in the clk after the tick_rise that caused them.

Simultaneous events:
- enable_i falling has priority over tick_rise: no cycle_o, no apply.
- load_i together with a boundary: the new inputs are applied immediately.

Test Plan:
1. Reset low mid-RUN with pwm_o = 1 -> all outputs 0 asynchronously; after release with enable_i = 0, the block stays IDLE and pwm_o stays 0 regardless of tick_i.
2. Load duty = 3, period = 8, enable_i = 1, tick_i toggling every 4 clk:
   - load_ack_o pulses at the first tick_rise.
   - pwm_o is high for 3 ticks and low for 5; cycle_o pulses every 8 ticks; count_o runs 0..7.
3. Running at 3/8, load duty = 6, period = 10 while count = 2:
   - load_pending_o = 1 until the wrap at count = 7, then load_ack_o pulses.
   - The next period is 10 ticks with 6 high; no short or long pulse appears in the old period.
4. Edge cases:
   - duty = 0, period = 5 -> pwm_o constant 0, cycle_o every 5 ticks.
   - duty = 9, period = 5 -> pwm_o constant 1.
   - period = 0 -> pwm_o 0, cycle_o every tick.
5. tick_i held high for 20 clk -> exactly one count increment; tick_i high at reset release -> no increment.
6. enable_i dropped at count = 4 -> next clk count = 0, pwm_o = 0, no cycle_o; re-enable -> START waits for tick_rise, then period restarts at count = 0 with cycle_o.
